hazard_ctrl: RTL

Pipeline hazard and forwarding controller for the 5-stage MIPS datapath. Decodes instr_D/E/M/W and drives the datapath's stall/flush controls (enable, clear) and forwarding-mux selects (MF_*_OP). Also schedules a multi-cycle mult/div unit with a busy countdown, stalling HI/LO consumers until it finishes. Sits beside the datapath in the CPU top; the main decoder still owns the per-stage control signals.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_ctrl_instr_class_dec.sv | 50 +++++
 rtl/hazard_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode/funct constants, instruction classes, forward selects and hazard timing helpers
package hazard_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV = 6'h1a, FN_DIVU = 6'h1b, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a;
  typedef enum logic [3:0] {
    CLS_NOP, CLS_CALC_R, CLS_CALC_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JR, CLS_MD, CLS_MF, CLS_MT
  } instr_class_t;
  localparam logic [1:0] FWD_REG = 2'd0, FWD_ALUC_M = 2'd1, FWD_PC4_M = 2'd2, FWD_WDATA = 2'd3;
  // TUSE_NONE marks a field the instruction does not read
  localparam logic [1:0] TUSE_0 = 2'd0, TUSE_1 = 2'd1, TUSE_2 = 2'd2, TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_JAL = 2'd0, TNEW_CALC = 2'd1, TNEW_LOAD = 2'd2;
  typedef struct packed {
    instr_class_t cls;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dst;
    logic [1:0]   tuse_rs;
    logic [1:0]   tuse_rt;
  } dec_t;
  function automatic logic [1:0] tnew_e(instr_class_t c);
    return c == CLS_LOAD ? TNEW_LOAD : (c inside {CLS_CALC_R, CLS_CALC_I, CLS_MF}) ? TNEW_CALC : TNEW_JAL;
  endfunction
  function automatic logic [1:0] tnew_m(instr_class_t c);
    return tnew_e(c) == 2'd0 ? 2'd0 : tnew_e(c) - 2'd1;
  endfunction
  // nearest younger writer decides: E shadows M
  function automatic logic stall_on(dec_t e, dec_t m, logic [4:0] r, logic [1:0] tuse);
    if (r == 5'd0 || tuse == TUSE_NONE) return 1'b0;
    if (e.dst == r) return tnew_e(e.cls) > tuse;
    return m.dst == r && tnew_m(m.cls) > tuse;
  endfunction
  // a load in M owns the register but has no data yet, so it also hides an older W writer
  function automatic logic [1:0] fwd_sel(dec_t m, dec_t w, logic [4:0] r);
    if (r != 5'd0 && m.dst == r) return m.cls == CLS_JAL ? FWD_PC4_M : m.cls == CLS_LOAD ? FWD_REG : FWD_ALUC_M;
    return (r != 5'd0 && w.dst == r) ? FWD_WDATA : FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_ctrl_instr_class_dec.sv
// instr_class_dec: classifies one instruction and reports its destination and rs/rt Tuse
module instr_class_dec
  import hazard_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);
  logic [5:0] op, fn;
  instr_class_t cls;
  logic unused_shamt;
  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];
  // opcode / funct to class
  always_comb begin
    cls = CLS_NOP;
    if (op == OP_SPECIAL)
      case (fn)
        FN_ADDU, FN_SUBU, FN_SLT, FN_AND, FN_OR, FN_SLL, FN_SRL: cls = CLS_CALC_R;
        FN_JR: cls = CLS_JR;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MD;
        FN_MFHI, FN_MFLO: cls = CLS_MF;
        FN_MTHI, FN_MTLO: cls = CLS_MT;
        default: cls = CLS_NOP;
      endcase
    else
      case (op)
        OP_ORI, OP_ADDIU, OP_LUI: cls = CLS_CALC_I;
        OP_LW: cls = CLS_LOAD;
        OP_SW: cls = CLS_STORE;
        OP_BEQ: cls = CLS_BRANCH;
        OP_JAL: cls = CLS_JAL;
        default: cls = CLS_NOP;
      endcase
  end
  // destination and operand timing from class
  always_comb begin
    dec_o.cls = cls;
    dec_o.rs = instr_i[25:21];
    dec_o.rt = instr_i[20:16];
    dec_o.dst = (cls inside {CLS_CALC_R, CLS_MF}) ? instr_i[15:11] :
                (cls inside {CLS_CALC_I, CLS_LOAD}) ? instr_i[20:16] :
                cls == CLS_JAL ? 5'd31 : 5'd0;
    dec_o.tuse_rs = (cls inside {CLS_BRANCH, CLS_JR}) ? TUSE_0 :
                    (cls inside {CLS_CALC_R, CLS_CALC_I, CLS_LOAD, CLS_STORE, CLS_MD, CLS_MT}) ? TUSE_1 : TUSE_NONE;
    dec_o.tuse_rt = cls == CLS_BRANCH ? TUSE_0 :
                    (cls inside {CLS_CALC_R, CLS_MD}) ? TUSE_1 :
                    cls == CLS_STORE ? TUSE_2 : TUSE_NONE;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush, forwarding selects and mult/div scheduling; HAZARD_PERF_CNT_EN adds stall_cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_M,
  input  logic [31:0] instr_W,
  output logic        enable,
  output logic        clear,
  output logic [1:0]  MF_RS_D_OP,
  output logic [1:0]  MF_RT_D_OP,
  output logic [1:0]  MF_RS_E_OP,
  output logic [1:0]  MF_RT_E_OP,
  output logic [1:0]  MF_RT_M_OP,
  output logic        md_start,
  output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  logic [31:0] instr [4];
  dec_t dec [4];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stall;
  assign instr = '{instr_D, instr_E, instr_M, instr_W};
  genvar g;
  for (g = 0; g < 4; g++) begin : g_dec
    instr_class_dec u_dec (.instr_i(instr[g]), .dec_o(dec[g]));
  end
  assign md_start = dec[1].cls == CLS_MD;
  assign md_busy = cnt_q != '0;
  assign stall = stall_on(dec[1], dec[2], dec[0].rs, dec[0].tuse_rs) ||
                 stall_on(dec[1], dec[2], dec[0].rt, dec[0].tuse_rt) ||
                 ((dec[0].cls inside {CLS_MD, CLS_MF, CLS_MT}) && (md_start || md_busy));
  assign enable = !stall;
  assign clear = stall;
  assign MF_RS_D_OP = fwd_sel(dec[2], dec[3], dec[0].rs);
  assign MF_RT_D_OP = fwd_sel(dec[2], dec[3], dec[0].rt);
  assign MF_RS_E_OP = fwd_sel(dec[2], dec[3], dec[1].rs);
  assign MF_RT_E_OP = fwd_sel(dec[2], dec[3], dec[1].rt);
  assign MF_RT_M_OP = (dec[2].cls == CLS_STORE && dec[2].rt != 5'd0 && dec[3].dst == dec[2].rt) ? 2'd1 : 2'd0;
  // funct bit 1 separates div/divu from mult/multu
  assign cnt_d = md_start ? (instr_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                 md_busy ? cnt_q - CNT_W'(1) : cnt_q;
  // busy countdown; reset aborts an operation in flight
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  // counts every stalled cycle, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else if (stall) stall_cycles_q <= stall_cycles_q + 32'd1;
  end
  assign stall_cycles = stall_cycles_q;
`endif
endmodule
